// File: rtl/traffic_control_unit_pkg.sv
// Shared encodings for the traffic control unit: FSM states, approach directions
// and the two-bit light codes the datapath muxes use.
package traffic_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_CLR   = 3'd0,
    ST_GN    = 3'd1,
    ST_GE    = 3'd2,
    ST_GS    = 3'd3,
    ST_GW    = 3'd4,
    ST_ECLR  = 3'd5,
    ST_EHOLD = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  localparam logic [1:0] LIGHT_GREEN = 2'b01;
  localparam logic [1:0] LIGHT_RED   = 2'b10;

  function automatic logic [1:0] light_code(input logic green);
    return green ? LIGHT_GREEN : LIGHT_RED;
  endfunction

  function automatic dir_e dir_next(input dir_e d);
    return dir_e'(d + 2'd1);
  endfunction

  function automatic state_e green_state(input dir_e d);
    return state_e'({1'b0, d} + 3'd1);
  endfunction

  // Direction served by a normal green state; non-green states map to North
  function automatic dir_e state_dir(input state_e s);
    case (s)
      ST_GE:   return DIR_E;
      ST_GS:   return DIR_S;
      ST_GW:   return DIR_W;
      default: return DIR_N;
    endcase
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_e d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/traffic_control_unit_tick_counter.sv
// Four-bit timebase tick counter with synchronous clear and saturation at 15.
module tick_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [3:0] o_cnt
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_en && (r_cnt != 4'hF)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_control_unit.sv
// Four-way intersection sequencer: N->E->S->W greens separated by all-red clearance,
// with a level-sensitive emergency override that can hold any single direction green.
module traffic_control_unit
  import traffic_control_unit_pkg::*;
#(
  parameter int GREEN_TICKS = 8,
  parameter int CLEAR_TICKS = 2
) (
  input  logic       CU_CLK,
  input  logic       CU_Rst,
  input  logic       CU_Tick,
  input  logic       CU_Emg,
  input  logic [1:0] CU_EmgDir,
  output logic       CU_North,
  output logic       CU_East,
  output logic       CU_South,
  output logic       CU_West,
  output logic [2:0] CU_Phase
);

  if ((GREEN_TICKS < 1) || (GREEN_TICKS > 15)) begin : g_bad_green
    $error("GREEN_TICKS must be in 1..15");
  end
  if ((CLEAR_TICKS < 1) || (CLEAR_TICKS > 15)) begin : g_bad_clear
    $error("CLEAR_TICKS must be in 1..15");
  end

  localparam logic [3:0] GREEN_LAST = 4'(GREEN_TICKS - 1);
  localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_TICKS - 1);

  state_e     r_state, w_next_state;
  dir_e       r_next_dir, w_next_dir;
  dir_e       r_emg_dir, w_emg_dir;
  dir_e       w_req_dir;
  logic [3:0] r_lights, w_lights;
  logic [3:0] w_cnt;
  logic       w_green_last, w_clear_last, w_clr;

  assign w_req_dir    = dir_e'(CU_EmgDir);
  assign w_green_last = CU_Tick && (w_cnt == GREEN_LAST);
  assign w_clear_last = CU_Tick && (w_cnt == CLEAR_LAST);
  assign w_clr        = (w_next_state != r_state);

  tick_counter u_tick_counter (
    .i_clk   (CU_CLK),
    .i_rst_n (CU_Rst),
    .i_clr   (w_clr),
    .i_en    (CU_Tick),
    .o_cnt   (w_cnt)
  );

  // Emergency conditions are tested before tick expiry so they always win
  always_comb begin
    w_next_state = r_state;
    w_next_dir   = r_next_dir;
    w_emg_dir    = r_emg_dir;
    case (r_state)
      ST_CLR: begin
        if (CU_Emg)            w_next_state = ST_ECLR;
        else if (w_clear_last) w_next_state = green_state(r_next_dir);
      end
      ST_GN, ST_GE, ST_GS, ST_GW: begin
        if (CU_Emg) begin
          w_next_state = (w_req_dir == state_dir(r_state)) ? ST_EHOLD : ST_ECLR;
        end else if (w_green_last) begin
          w_next_state = ST_CLR;
          w_next_dir   = dir_next(r_next_dir);
        end
      end
      ST_ECLR: begin
        if (!CU_Emg) begin
          w_next_state = ST_CLR;
          w_next_dir   = dir_next(r_emg_dir);
        end else if (w_clear_last) begin
          w_next_state = ST_EHOLD;
        end
      end
      ST_EHOLD: begin
        if (!CU_Emg) begin
          w_next_state = ST_CLR;
          w_next_dir   = dir_next(r_emg_dir);
        end else if (w_req_dir != r_emg_dir) begin
          w_next_state = ST_ECLR;
        end
      end
      default: w_next_state = ST_CLR;
    endcase

    if (CU_Emg && ((w_next_state == ST_ECLR) || (w_next_state == ST_EHOLD))) begin
      w_emg_dir = w_req_dir;
    end

    // Lights are decoded from the next state so the registered outputs track the state register
    w_lights = 4'b0000;
    case (w_next_state)
      ST_GN, ST_GE, ST_GS, ST_GW: w_lights = dir_onehot(state_dir(w_next_state));
      ST_EHOLD:                   w_lights = dir_onehot(w_emg_dir);
      default:                    w_lights = 4'b0000;
    endcase
  end

  always_ff @(posedge CU_CLK or negedge CU_Rst) begin
    if (!CU_Rst) begin
      r_state    <= ST_CLR;
      r_next_dir <= DIR_N;
      r_emg_dir  <= DIR_N;
      r_lights   <= 4'b0000;
    end else begin
      r_state    <= w_next_state;
      r_next_dir <= w_next_dir;
      r_emg_dir  <= w_emg_dir;
      r_lights   <= w_lights;
    end
  end

  assign CU_North = r_lights[0];
  assign CU_East  = r_lights[1];
  assign CU_South = r_lights[2];
  assign CU_West  = r_lights[3];
  assign CU_Phase = r_state;

endmodule

// File: tb/tb_traffic_control_unit.sv
// Directed bench for traffic_control_unit: expectations are queued as each stimulus
// step is driven and compared once the DUT has clocked that step.
module tb_traffic_control_unit;
  import traffic_control_unit_pkg::*;

  logic       CU_CLK = 1'b0;
  logic       CU_Rst;
  logic       CU_Tick;
  logic       CU_Emg;
  logic [1:0] CU_EmgDir;
  logic       CU_North, CU_East, CU_South, CU_West;
  logic [2:0] CU_Phase;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic [3:0] lights;
  } exp_t;

  exp_t sb[$];

  localparam logic [3:0] L_N = 4'b0001;
  localparam logic [3:0] L_E = 4'b0010;
  localparam logic [3:0] L_S = 4'b0100;
  localparam logic [3:0] L_W = 4'b1000;
  localparam logic [3:0] L_0 = 4'b0000;

  traffic_control_unit #(
    .GREEN_TICKS (8),
    .CLEAR_TICKS (2)
  ) dut (
    .CU_CLK    (CU_CLK),
    .CU_Rst    (CU_Rst),
    .CU_Tick   (CU_Tick),
    .CU_Emg    (CU_Emg),
    .CU_EmgDir (CU_EmgDir),
    .CU_North  (CU_North),
    .CU_East   (CU_East),
    .CU_South  (CU_South),
    .CU_West   (CU_West),
    .CU_Phase  (CU_Phase)
  );

  always #5 CU_CLK = ~CU_CLK;

  always @(negedge CU_CLK) begin
    if (CU_Rst) begin
      n_checks++;
      assert ($countones({CU_West, CU_South, CU_East, CU_North}) <= 1) n_pass++;
      else $error("FAIL onehot observed=%b required=at most one set",
                  {CU_West, CU_South, CU_East, CU_North});
    end
  end

  task automatic push(input string tag, input logic [2:0] ph, input logic [3:0] l);
    exp_t e;
    e.tag = tag; e.ph = ph; e.lights = l;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [6:0] obs;
    n_checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard observed=empty required=pending entry");
    end else begin
      e   = sb.pop_front();
      obs = {CU_Phase, CU_West, CU_South, CU_East, CU_North};
      assert (obs === {e.ph, e.lights}) n_pass++;
      else $error("FAIL %s observed phase=%0d lights=%b required phase=%0d lights=%b",
                  e.tag, obs[6:4], obs[3:0], e.ph, e.lights);
    end
  endtask

  task automatic cyc(input bit t);
    CU_Tick = t;
    @(posedge CU_CLK);
    #1;
    CU_Tick = 1'b0;
  endtask

  task automatic cyc_chk(input string tag, input bit t, input logic [2:0] ph, input logic [3:0] l);
    push(tag, ph, l);
    cyc(t);
    pop_check();
  endtask

  task automatic tick_chk(input string tag, input logic [2:0] ph, input logic [3:0] l);
    cyc_chk(tag, 1'b1, ph, l);
    repeat (3) cyc(1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(1'b1);
      repeat (3) cyc(1'b0);
    end
  endtask

  initial begin
    CU_Rst = 1'b0; CU_Tick = 1'b0; CU_Emg = 1'b0; CU_EmgDir = 2'd0;
    cyc_chk("reset", 1'b1, ST_CLR, L_0);
    #3 CU_Rst = 1'b1;
    cyc(1'b0);

    // Normal rotation N, E, S, W, N
    tick_chk("clr_t1", ST_CLR, L_0);
    tick_chk("first_gn", ST_GN, L_N);
    for (int i = 0; i < 4; i++) begin
      ticks(6);
      tick_chk("green_t7", 3'(i + 1), 4'(4'b0001 << i));
      tick_chk("green_end", ST_CLR, L_0);
      tick_chk("clr_t1", ST_CLR, L_0);
      tick_chk("next_green", 3'(((i + 1) % 4) + 1), 4'(4'b0001 << ((i + 1) % 4)));
    end

    // Emergency matching the active green goes straight to hold
    CU_Emg = 1'b1; CU_EmgDir = 2'd0;
    cyc_chk("ehold_n", 1'b0, ST_EHOLD, L_N);
    cyc_chk("ehold_n_keep", 1'b1, ST_EHOLD, L_N);

    CU_EmgDir = 2'd1;
    cyc_chk("ehold_dirchg", 1'b0, ST_ECLR, L_0);
    tick_chk("eclr_t1", ST_ECLR, L_0);
    tick_chk("ehold_e", ST_EHOLD, L_E);

    CU_Emg = 1'b0;
    cyc_chk("emg_exit_e", 1'b0, ST_CLR, L_0);
    tick_chk("clr_t1", ST_CLR, L_0);
    tick_chk("succ_of_e", ST_GS, L_S);

    // Asynchronous reset in the middle of South green
    ticks(2);
    #3 CU_Rst = 1'b0;
    #1 push("rst_async", ST_CLR, L_0);
    pop_check();
    cyc(1'b0);
    #3 CU_Rst = 1'b1;
    cyc(1'b0);
    tick_chk("rst_clr_t1", ST_CLR, L_0);
    tick_chk("rst_first_gn", ST_GN, L_N);

    // Emergency and final green tick together: emergency wins
    ticks(7);
    CU_Emg = 1'b1; CU_EmgDir = 2'd2;
    cyc_chk("emg_vs_last", 1'b1, ST_ECLR, L_0);
    repeat (3) cyc(1'b0);
    tick_chk("eclr_t1", ST_ECLR, L_0);
    tick_chk("ehold_s", ST_EHOLD, L_S);
    ticks(20);
    tick_chk("ehold_sat", ST_EHOLD, L_S);
    CU_Emg = 1'b0;
    cyc_chk("emg_exit_s", 1'b0, ST_CLR, L_0);
    tick_chk("clr_t1", ST_CLR, L_0);
    tick_chk("succ_of_s", ST_GW, L_W);

    // Walk to East green, then emergency South on its third tick
    ticks(7);
    tick_chk("gw_end", ST_CLR, L_0);
    ticks(1);
    tick_chk("gn_again", ST_GN, L_N);
    ticks(7);
    tick_chk("gn_end", ST_CLR, L_0);
    ticks(1);
    tick_chk("ge_again", ST_GE, L_E);
    ticks(2);
    CU_Emg = 1'b1; CU_EmgDir = 2'd2;
    cyc_chk("ge_t3_emg", 1'b1, ST_ECLR, L_0);
    repeat (3) cyc(1'b0);
    tick_chk("eclr_t1", ST_ECLR, L_0);
    tick_chk("ehold_s2", ST_EHOLD, L_S);
    cyc_chk("ehold_s2_keep", 1'b0, ST_EHOLD, L_S);
    CU_Emg = 1'b0;
    cyc_chk("emg_exit_s2", 1'b0, ST_CLR, L_0);
    tick_chk("clr_t1", ST_CLR, L_0);
    tick_chk("west_after_emg", ST_GW, L_W);

    // Emergency raised during clearance, then dropped before hold
    ticks(7);
    tick_chk("gw_end2", ST_CLR, L_0);
    CU_Emg = 1'b1; CU_EmgDir = 2'd0;
    cyc_chk("clr_emg", 1'b0, ST_ECLR, L_0);
    CU_Emg = 1'b0;
    cyc_chk("eclr_drop", 1'b0, ST_CLR, L_0);
    tick_chk("clr_t1", ST_CLR, L_0);
    tick_chk("succ_of_n", ST_GE, L_E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_control_unit.md
TRAFFIC_CONTROL_UNIT -- requirements
Module: traffic_control_unit

Interface
REQ-001 Parameter GREEN_TICKS, default 8, sets the green-phase length in CU_Tick pulses (legal 1..15).
REQ-002 Parameter CLEAR_TICKS, default 2, sets the all-red clearance length in CU_Tick pulses (legal 1..15).
REQ-003 CU_CLK  input  1  single clock; all state updates occur on its rising edge.
REQ-004 CU_Rst  input  1  asynchronous, active-low reset.
REQ-005 CU_Tick  input  1  one-cycle timebase pulse from the datapath counter flag.
REQ-006 CU_Emg  input  1  emergency override request, level-sensitive.
REQ-007 CU_EmgDir  input  2  emergency direction: 00=North, 01=East, 10=South, 11=West.
REQ-008 CU_North, CU_East, CU_South, CU_West  output  1 each  mux select to the datapath: 1=Green, 0=Red.
REQ-009 CU_Phase  output  3  current state encoding, for debug and the bench.

Function
REQ-010 States SHALL be: CLR (all red), G_N, G_E, G_S, G_W, ECLR (emergency all red), EHOLD (emergency green).
REQ-011 Each CU_* output SHALL be registered; at most one SHALL be 1 in any cycle.
REQ-012 In CLR, ECLR and after reset, all four CU_* outputs SHALL be 0.
REQ-013 A 4-bit tick counter SHALL increment on each CU_Tick, and SHALL clear to 0 on every state change.
REQ-014 A 2-bit next-direction register SHALL hold the next green direction, in the fixed order N -> E -> S -> W -> N.
REQ-015 In CLR: on the CU_Tick where the count equals CLEAR_TICKS-1, the state SHALL go to the green state of next-direction.
REQ-016 In G_x: on the CU_Tick where the count equals GREEN_TICKS-1, the state SHALL go to CLR, and next-direction SHALL advance by one (wrapping W -> N).
REQ-017 Outputs SHALL change in the cycle after the qualifying CU_Tick edge (one-cycle latency).
REQ-018 CU_Emg=1 in CLR or in a non-matching G_x SHALL go to ECLR on the next edge, regardless of CU_Tick.
REQ-019 CU_Emg=1 in the G_x matching CU_EmgDir SHALL go straight to EHOLD, with the same green held and no red glitch.
REQ-020 In ECLR: on the CU_Tick where the count equals CLEAR_TICKS-1 with CU_Emg=1, the state SHALL go to EHOLD.
REQ-021 EHOLD SHALL drive green only on the direction latched on entry.
REQ-022 In EHOLD, a change of CU_EmgDir while CU_Emg=1 SHALL go to ECLR and latch the new direction.
REQ-023 In EHOLD or ECLR, CU_Emg=0 SHALL go to CLR; next-direction SHALL be set to the successor of the latched emergency direction.
REQ-024 When CU_Emg and a qualifying CU_Tick occur in the same cycle, the emergency rule SHALL take priority.
REQ-025 The tick counter SHALL saturate at 15 and never wrap.

Reset
REQ-026 CU_Rst=0 SHALL immediately force: state=CLR, counter=0, next-direction=North, latched emergency direction=North, all CU_*=0, CU_Phase=CLR.
REQ-027 Reset deasserted mid-cycle SHALL resume normal operation from CLR at the next CU_CLK edge.

Structure
REQ-028 A shared package SHALL hold the state encoding, the direction encoding, and the Green=01 / Red=10 light constants used by the datapath.
REQ-029 The design SHALL be a single FSM module; one sub-module, tick_counter (clear, enable, saturate), is permitted.
REQ-030 Parameter legality SHALL be checked at elaboration.

Verification
REQ-031 Reset, then CU_Tick every 4 cycles with defaults -> green order N, E, S, W, N; each green lasts 8 ticks; 2-tick all-red between greens; one-hot never violated.
REQ-032 During G_E tick 3, CU_Emg=1 with CU_EmgDir=10 -> all red next cycle; after 2 ticks South green holds while CU_Emg=1; CU_Emg=0 -> CLR then West green.
REQ-033 During G_N, CU_Emg=1 with CU_EmgDir=00 -> CU_North stays 1 continuously; CU_Phase=EHOLD.
REQ-034 In EHOLD North, CU_EmgDir changes to 01 -> ECLR for 2 ticks, then East green.
REQ-035 CU_Emg and the final green tick asserted in the same cycle -> ECLR, not CLR.
REQ-036 CU_Rst pulsed low mid-G_S -> all outputs 0 asynchronously; first green after release is North.
